// File: rtl/servo_ramp_controller_if.sv
// Servo ramp controller bus: shared position word, per-channel load strobes,
// and the registered PWM / frame / settled outputs.
interface servo_ramp_controller_if #(
   parameter int CHANNELS = 4,
   parameter int DUTY_W   = 8
);
   logic [DUTY_W-1:0]   duty;
   logic [CHANNELS-1:0] latch;
   logic [CHANNELS-1:0] PWMOut;
   logic                frame_tick;
   logic [CHANNELS-1:0] settled;

   modport master (
      output duty,
      output latch,
      input  PWMOut,
      input  frame_tick,
      input  settled
   );

   modport slave (
      input  duty,
      input  latch,
      output PWMOut,
      output frame_tick,
      output settled
   );
endinterface

// File: rtl/servo_ramp_controller.sv
// Multi-channel servo PWM generator with per-frame position slewing.
// Each channel holds a target (loaded by its latch strobe) and a position that
// moves toward the target once per frame; the pulse width for a frame is
// MIN_CLKS + position*UNIT_CLKS, fixed at the frame boundary.
// Build option: define SERVO_RAMP_EN to limit the position change to STEP per
// frame; without it the position jumps straight to the target each frame.
module servo_ramp_controller #(
   parameter int CHANNELS   = 4,
   parameter int DUTY_W     = 8,
   parameter int FRAME_CLKS = 1_000_000,
   parameter int MIN_CLKS   = 50_000,
   parameter int UNIT_CLKS  = 195,
   parameter int STEP       = 4,
   parameter int RESET_POS  = 128
) (
   input  logic                   clock,
   input  logic                   reset,
   servo_ramp_controller_if.slave bus
);

   localparam int CNT_W = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CLKS - 1);
   localparam longint MAX_THR = longint'(MIN_CLKS)
                              + ((longint'(1) << DUTY_W) - 1) * longint'(UNIT_CLKS);
   localparam logic [DUTY_W-1:0] POS_RST = DUTY_W'(RESET_POS);
   localparam logic [CNT_W-1:0]  THR_RST = CNT_W'(longint'(MIN_CLKS)
                                         + longint'(RESET_POS) * longint'(UNIT_CLKS));

   // The longest pulse must leave at least one low cycle in the frame.
   if ((MAX_THR >= longint'(FRAME_CLKS)) || (STEP == 0)) begin : g_bad_params
      $error("servo_ramp_controller: pulse range exceeds frame or STEP is zero");
   end

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                restart_q;
   logic                wrap;
   logic                frame_tick_q, frame_tick_d;
   logic [CHANNELS-1:0] pwm_q, pwm_d;
   logic [CHANNELS-1:0] settled_q, settled_d;
   logic [DUTY_W-1:0]   pos_q [CHANNELS];
   logic [DUTY_W-1:0]   pos_d [CHANNELS];
   logic [DUTY_W-1:0]   tgt_q [CHANNELS];
   logic [DUTY_W-1:0]   tgt_d [CHANNELS];
   logic [CNT_W-1:0]    thr_q [CHANNELS];
   logic [CNT_W-1:0]    thr_d [CHANNELS];

   // Pulse length for a position; the result always fits CNT_W bits because
   // the largest threshold is checked to be below FRAME_CLKS.
   function automatic logic [CNT_W-1:0] calc_thr(input logic [DUTY_W-1:0] p);
      return CNT_W'(MIN_CLKS) + CNT_W'(p) * CNT_W'(UNIT_CLKS);
   endfunction

`ifdef SERVO_RAMP_EN
   // One slew step toward the target, landing exactly on it when close enough.
   function automatic logic [DUTY_W-1:0] next_pos(input logic [DUTY_W-1:0] p,
                                                  input logic [DUTY_W-1:0] t);
      int diff;
      diff = int'(t) - int'(p);
      if (diff > STEP)
         return p + DUTY_W'(STEP);
      else if (diff < -STEP)
         return p - DUTY_W'(STEP);
      else
         return t;
   endfunction
`endif

   // Next-state: frame counter, target loads, boundary position/threshold update, outputs.
   always_comb begin
      wrap  = 1'b0;
      cnt_d = cnt_q;
      // The edge that releases reset starts a fresh frame at count 0.
      if (restart_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         wrap  = 1'b1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      frame_tick_d = (cnt_d == '0);

      for (int i = 0; i < CHANNELS; i++) begin
         tgt_d[i] = bus.latch[i] ? bus.duty : tgt_q[i];
         // Boundary update reads tgt_q, so a latch on the wrap edge waits a frame.
`ifdef SERVO_RAMP_EN
         pos_d[i] = wrap ? next_pos(pos_q[i], tgt_q[i]) : pos_q[i];
`else
         pos_d[i] = wrap ? tgt_q[i] : pos_q[i];
`endif
         thr_d[i]     = wrap ? calc_thr(pos_d[i]) : thr_q[i];
         pwm_d[i]     = (cnt_d < thr_d[i]);
         settled_d[i] = (pos_d[i] == tgt_d[i]);
      end
   end

   // State registers with synchronous reset to the centred rest position.
   always_ff @(posedge clock) begin
      if (reset) begin
         restart_q    <= 1'b1;
         cnt_q        <= '0;
         frame_tick_q <= 1'b0;
         pwm_q        <= '0;
         settled_q    <= '1;
         for (int i = 0; i < CHANNELS; i++) begin
            pos_q[i] <= POS_RST;
            tgt_q[i] <= POS_RST;
            thr_q[i] <= THR_RST;
         end
      end else begin
         restart_q    <= 1'b0;
         cnt_q        <= cnt_d;
         frame_tick_q <= frame_tick_d;
         pwm_q        <= pwm_d;
         settled_q    <= settled_d;
         for (int i = 0; i < CHANNELS; i++) begin
            pos_q[i] <= pos_d[i];
            tgt_q[i] <= tgt_d[i];
            thr_q[i] <= thr_d[i];
         end
      end
   end

   assign bus.PWMOut     = pwm_q;
   assign bus.frame_tick = frame_tick_q;
   assign bus.settled    = settled_q;

endmodule

// File: tb/tb_servo_ramp_controller.sv
// Directed bench for servo_ramp_controller with a short frame so that full
// ramps fit in a few tens of thousands of cycles. Pulse widths scale as
// MINC + position*UNIT; expectations follow SERVO_RAMP_EN when defined.
module tb_servo_ramp_controller;
   localparam int CH   = 4;
   localparam int DW   = 8;
   localparam int FR   = 300;
   localparam int MINC = 20;
   localparam int UNIT = 1;
   localparam int STP  = 4;
   localparam int RPOS = 128;
   localparam int W_RST = MINC + RPOS * UNIT;  // 148
   localparam int W_MAX = MINC + 255 * UNIT;   // 275
   localparam int W_MIN = MINC;                // 20

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   servo_ramp_controller_if #(.CHANNELS(CH), .DUTY_W(DW)) bus ();

   servo_ramp_controller #(
      .CHANNELS(CH), .DUTY_W(DW), .FRAME_CLKS(FR), .MIN_CLKS(MINC),
      .UNIT_CLKS(UNIT), .STEP(STP), .RESET_POS(RPOS)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;
   int w [CH];
   logic [CH-1:0] st0, st_end;
   bit shape_ok;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Runs one frame starting in its frame_tick cycle (sampled at negedge),
   // measuring each channel's pulse; optionally drives a latch in cycle lat_k.
   task automatic run_frame(input int lat_k, input logic [CH-1:0] lat_m, input logic [DW-1:0] lat_d);
      bit seen_low [CH];
      shape_ok = 1'b1;
      for (int c = 0; c < CH; c++) begin
         w[c] = 0;
         seen_low[c] = 1'b0;
      end
      chk("frame_tick_at_start", 64'(bus.frame_tick), 64'(1));
      st0 = bus.settled;
      for (int k = 0; k < FR; k++) begin
         for (int c = 0; c < CH; c++) begin
            if (bus.PWMOut[c]) begin
               if (seen_low[c]) shape_ok = 1'b0;
               w[c]++;
            end else begin
               seen_low[c] = 1'b1;
            end
         end
         if (k > 0 && bus.frame_tick) shape_ok = 1'b0;
         if (k == FR - 1) st_end = bus.settled;
         if (k == lat_k) begin
            bus.duty  = lat_d;
            bus.latch = lat_m;
         end
         @(negedge clock);
         bus.latch = '0;
      end
      chk("pulse_shape", 64'(shape_ok), 64'(1));
   endtask

   initial begin
      int p;
      bus.duty  = '0;
      bus.latch = '0;
      reset     = 1'b1;
      repeat (3) @(negedge clock);

      // Reset state
      chk("reset_pwm", 64'(bus.PWMOut), 64'(0));
      chk("reset_tick", 64'(bus.frame_tick), 64'(0));
      chk("reset_settled", 64'(bus.settled), 64'hF);

      // Latch during reset must be ignored
      bus.duty  = 8'h00;
      bus.latch = '1;
      @(negedge clock);
      bus.latch = '0;
      chk("reset_latch_ignored_settled", 64'(bus.settled), 64'hF);

      // Release: first cycle is a tick with all pulses high
      reset = 1'b0;
      @(negedge clock);
      chk("release_pwm", 64'(bus.PWMOut), 64'hF);

      // Frame 1: latch FF to all channels mid-pulse; this pulse is unchanged
      run_frame(50, 4'hF, 8'hFF);
      for (int c = 0; c < CH; c++) chk($sformatf("f1_width_ch%0d", c), 64'(w[c]), 64'(W_RST));
      chk("f1_settled_start", 64'(st0), 64'hF);
      chk("f1_settled_after_latch", 64'(st_end), 64'h0);

      // Ramp up to 255
      for (int b = 1; b <= 33; b++) begin
`ifdef SERVO_RAMP_EN
         p = (RPOS + STP * b > 255) ? 255 : RPOS + STP * b;
`else
         p = 255;
`endif
         run_frame(-1, '0, '0);
         for (int c = 0; c < CH; c++)
            chk($sformatf("up_b%0d_ch%0d", b, c), 64'(w[c]), 64'(MINC + p * UNIT));
         chk($sformatf("up_b%0d_settled", b), 64'(st0), (p == 255) ? 64'hF : 64'h0);
      end

      // Channel 0 to 0, latched mid-pulse
      run_frame(10, 4'b0001, 8'h00);
      for (int c = 0; c < CH; c++) chk($sformatf("dn_latch_ch%0d", c), 64'(w[c]), 64'(W_MAX));
      chk("dn_settled_after_latch", 64'(st_end), 64'hE);

      for (int b = 1; b <= 65; b++) begin
`ifdef SERVO_RAMP_EN
         p = (255 - STP * b < 0) ? 0 : 255 - STP * b;
`else
         p = 0;
`endif
         run_frame(-1, '0, '0);
         chk($sformatf("dn_b%0d_ch0", b), 64'(w[0]), 64'(MINC + p * UNIT));
         for (int c = 1; c < CH; c++)
            chk($sformatf("dn_b%0d_ch%0d", b, c), 64'(w[c]), 64'(W_MAX));
         chk($sformatf("dn_b%0d_settled", b), 64'(st0), (p == 0) ? 64'hF : 64'hE);
      end

      // Latch channel 1 on the wrap edge: no change at that boundary
      run_frame(FR - 1, 4'b0010, 8'd100);
      chk("wrap_latch_ch0", 64'(w[0]), 64'(W_MIN));
      chk("wrap_latch_ch1", 64'(w[1]), 64'(W_MAX));
      run_frame(-1, '0, '0);
      chk("wrap_next_ch1", 64'(w[1]), 64'(W_MAX));
      chk("wrap_next_settled", 64'(st0), 64'hD);
      run_frame(-1, '0, '0);
`ifdef SERVO_RAMP_EN
      chk("wrap_later_ch1", 64'(w[1]), 64'(MINC + 251 * UNIT));
`else
      chk("wrap_later_ch1", 64'(w[1]), 64'(MINC + 100 * UNIT));
`endif
      chk("wrap_later_ch2", 64'(w[2]), 64'(W_MAX));

      // Reset mid-pulse at counter 30
      repeat (30) @(negedge clock);
      chk("pre_reset_ch3_high", 64'(bus.PWMOut[3]), 64'(1));
      reset = 1'b1;
      @(negedge clock);
      chk("midreset_pwm", 64'(bus.PWMOut), 64'(0));
      chk("midreset_tick", 64'(bus.frame_tick), 64'(0));
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      run_frame(-1, '0, '0);
      for (int c = 0; c < CH; c++) chk($sformatf("rst_f1_ch%0d", c), 64'(w[c]), 64'(W_RST));
      chk("rst_f1_settled", 64'(st0), 64'hF);
      run_frame(-1, '0, '0);
      for (int c = 0; c < CH; c++) chk($sformatf("rst_f2_ch%0d", c), 64'(w[c]), 64'(W_RST));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
